rptr_empty_level: RTL and testbench

- Read-domain pointer and status controller of the async FIFO.
- Sits directly downstream of the write-to-read pointer synchronizer and consumes its two-flop-synchronized Gray write pointer (rq2_wptr).
- Owns the read binary/Gray pointers and drives the RAM read address.
- Produces the empty and almost-empty flags, a registered fill level and a sticky underflow flag.
- Its Gray read pointer feeds the read-to-write synchronizer.

---
 rtl/async_fifo_pkg.sv | 34 +++
 rtl/rptr_empty_level.sv | 88 ++++++++
 tb/tb_rptr_empty_level.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/async_fifo_pkg.sv
// Shared async-FIFO helpers: depth derivation and width-masked Gray/binary conversion.
// Used by both the read-side empty logic and the write-side full logic.
package async_fifo_pkg;

  localparam int unsigned MAXW = 32;

  function automatic int unsigned depth_of(input int unsigned addrsize);
    return 32'(1) << addrsize;
  endfunction

  function automatic logic [MAXW-1:0] width_mask(input int unsigned w);
    logic [MAXW-1:0] m;
    if (w >= MAXW) m = '1;
    else           m = (MAXW'(1) << w) - MAXW'(1);
    return m;
  endfunction

  function automatic logic [MAXW-1:0] bin2gray(input logic [MAXW-1:0] b, input int unsigned w);
    logic [MAXW-1:0] bm;
    bm = b & width_mask(w);
    return (bm >> 1) ^ bm;
  endfunction

  // Prefix-XOR from the MSB down, done by log-step doubling shifts.
  function automatic logic [MAXW-1:0] gray2bin(input logic [MAXW-1:0] g, input int unsigned w);
    logic [MAXW-1:0] b;
    b = g & width_mask(w);
    for (int s = 1; s < int'(MAXW); s = s * 2) begin
      b = b ^ (b >> s);
    end
    return b;
  endfunction

endpackage

// File: rtl/rptr_empty_level.sv
// Read-domain pointer/status controller of the async FIFO: read pointers, RAM
// address, empty/almost-empty flags, fill level and sticky underflow.
module rptr_empty_level
  import async_fifo_pkg::*;
#(
  parameter int unsigned ADDRSIZE      = 3,
  parameter int unsigned AEMPTY_THRESH = 1
) (
  input  logic                rclk,
  input  logic                rrst_n,
  input  logic                rinc,
  input  logic [ADDRSIZE:0]   rq2_wptr,
  output logic [ADDRSIZE-1:0] raddr,
  output logic [ADDRSIZE:0]   rptr,
  output logic                rempty,
  output logic                raempty,
  output logic [ADDRSIZE:0]   rlevel,
  output logic                runderflow
);

  localparam int unsigned PW    = ADDRSIZE + 1;
  localparam int unsigned DEPTH = depth_of(ADDRSIZE);

  logic [PW-1:0] rbin_q,  rbin_d;
  logic [PW-1:0] rptr_q,  rptr_d;
  logic [PW-1:0] rlevel_q, rlevel_d;
  logic          rempty_q, rempty_d;
  logic          raempty_q, raempty_d;
  logic          runderflow_q, runderflow_d;

  logic          rd_en;
  logic [PW-1:0] wbin;
  logic [PW-1:0] level_next;

  // Flags compare against the next pointer so the last read empties without a bubble.
  always_comb begin
    rd_en        = 1'b0;
    rbin_d       = rbin_q;
    rptr_d       = rptr_q;
    wbin         = '0;
    level_next   = '0;
    rempty_d     = rempty_q;
    raempty_d    = raempty_q;
    rlevel_d     = rlevel_q;
    runderflow_d = runderflow_q;

    rd_en        = rinc & ~rempty_q;
    rbin_d       = rbin_q + PW'(rd_en);
    rptr_d       = PW'(bin2gray(MAXW'(rbin_d), PW));
    wbin         = PW'(gray2bin(MAXW'(rq2_wptr), PW));
    level_next   = wbin - rbin_d;
    rempty_d     = (rptr_d == rq2_wptr);
    raempty_d    = (MAXW'(level_next) <= AEMPTY_THRESH);
    rlevel_d     = level_next;
    runderflow_d = runderflow_q | (rinc & rempty_q);
  end

  // Reset is asserted high on this block's rrst_n.
  always_ff @(posedge rclk or posedge rrst_n) begin
    if (rrst_n) begin
      rbin_q       <= '0;
      rptr_q       <= '0;
      rlevel_q     <= '0;
      rempty_q     <= 1'b1;
      raempty_q    <= 1'b1;
      runderflow_q <= 1'b0;
    end else begin
      rbin_q       <= rbin_d;
      rptr_q       <= rptr_d;
      rlevel_q     <= rlevel_d;
      rempty_q     <= rempty_d;
      raempty_q    <= raempty_d;
      runderflow_q <= runderflow_d;
    end
  end

  assign raddr      = rbin_q[ADDRSIZE-1:0];
  assign rptr       = rptr_q;
  assign rempty     = rempty_q;
  assign raempty    = raempty_q;
  assign rlevel     = rlevel_q;
  assign runderflow = runderflow_q;

  // A level above DEPTH means the synchronizer or writer is broken; not clamped.
  a_level_in_range: assert property (@(posedge rclk) disable iff (rrst_n)
    MAXW'(rlevel_q) <= DEPTH);

endmodule

// File: tb/tb_rptr_empty_level.sv
// Directed bench for rptr_empty_level (ADDRSIZE=3, AEMPTY_THRESH=1).
module tb_rptr_empty_level;

  logic       rclk;
  logic       rrst_n;
  logic       rinc;
  logic [3:0] rq2_wptr;
  logic [2:0] raddr;
  logic [3:0] rptr;
  logic       rempty;
  logic       raempty;
  logic [3:0] rlevel;
  logic       runderflow;

  int n_total;
  int n_bad;
  logic [3:0] gtab [16];

  rptr_empty_level #(.ADDRSIZE(3), .AEMPTY_THRESH(1)) dut (
    .rclk      (rclk),
    .rrst_n    (rrst_n),
    .rinc      (rinc),
    .rq2_wptr  (rq2_wptr),
    .raddr     (raddr),
    .rptr      (rptr),
    .rempty    (rempty),
    .raempty   (raempty),
    .rlevel    (rlevel),
    .runderflow(runderflow)
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Inputs change at negedge; one posedge; sample at the following negedge.
  task automatic cyc;
    @(posedge rclk);
    @(negedge rclk);
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    gtab = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
             4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000};
    rrst_n   = 1'b1;
    rinc     = 1'b0;
    rq2_wptr = 4'b0000;
    repeat (3) @(posedge rclk);
    @(negedge rclk);
    chk("rst_rptr",    32'(rptr),       32'h0);
    chk("rst_raddr",   32'(raddr),      32'h0);
    chk("rst_rempty",  32'(rempty),     32'h1);
    chk("rst_raempty", 32'(raempty),    32'h1);
    chk("rst_rlevel",  32'(rlevel),     32'h0);
    chk("rst_under",   32'(runderflow), 32'h0);

    rrst_n = 1'b0;
    cyc();
    chk("idle_rempty", 32'(rempty), 32'h1);

    // Fill: writer at binary 3
    rq2_wptr = 4'b0010;
    cyc();
    chk("fill_rempty",  32'(rempty),  32'h0);
    chk("fill_rlevel",  32'(rlevel),  32'h3);
    chk("fill_raempty", 32'(raempty), 32'h0);
    chk("fill_raddr",   32'(raddr),   32'h0);

    // Drain three entries
    rinc = 1'b1;
    cyc();
    chk("dr1_raddr",   32'(raddr),   32'h1);
    chk("dr1_rlevel",  32'(rlevel),  32'h2);
    chk("dr1_raempty", 32'(raempty), 32'h0);
    cyc();
    chk("dr2_raddr",   32'(raddr),   32'h2);
    chk("dr2_rlevel",  32'(rlevel),  32'h1);
    chk("dr2_raempty", 32'(raempty), 32'h1);
    chk("dr2_rempty",  32'(rempty),  32'h0);
    cyc();
    chk("dr3_rlevel",  32'(rlevel), 32'h0);
    chk("dr3_rempty",  32'(rempty), 32'h1);
    chk("dr3_rptr",    32'(rptr),   32'h2);
    chk("dr3_raddr",   32'(raddr),  32'h3);

    // Underflow: rinc still high while empty
    cyc();
    chk("uf_raddr", 32'(raddr),      32'h3);
    chk("uf_rptr",  32'(rptr),       32'h2);
    chk("uf_flag",  32'(runderflow), 32'h1);
    rinc = 1'b0;
    cyc();
    chk("uf_sticky", 32'(runderflow), 32'h1);

    // Advance rbin to 5 with writer at binary 6
    rq2_wptr = 4'b0101;
    cyc();
    chk("r5_fill_rlevel", 32'(rlevel), 32'h3);
    rinc = 1'b1;
    cyc();
    cyc();
    rinc = 1'b0;
    chk("r5_raddr",   32'(raddr),   32'h5);
    chk("r5_rptr",    32'(rptr),    32'h7);
    chk("r5_rlevel",  32'(rlevel),  32'h1);
    chk("r5_raempty", 32'(raempty), 32'h1);

    // Asynchronous reset between clock edges
    #2;
    rrst_n   = 1'b1;
    rq2_wptr = 4'b0000;
    #1;
    chk("arst_rptr",    32'(rptr),       32'h0);
    chk("arst_raddr",   32'(raddr),      32'h0);
    chk("arst_rempty",  32'(rempty),     32'h1);
    chk("arst_raempty", 32'(raempty),    32'h1);
    chk("arst_rlevel",  32'(rlevel),     32'h0);
    chk("arst_under",   32'(runderflow), 32'h0);
    @(negedge rclk);
    rrst_n = 1'b0;

    // Wrap: writer 4 ahead, both advance one per cycle through the pointer rollover
    rq2_wptr = gtab[4];
    cyc();
    chk("wr_start_rlevel", 32'(rlevel), 32'h4);
    rinc = 1'b1;
    for (int i = 1; i <= 18; i++) begin
      rq2_wptr = gtab[(4 + i) % 16];
      cyc();
      chk("wr_rptr",    32'(rptr),    32'(gtab[i % 16]));
      chk("wr_raddr",   32'(raddr),   32'(i % 8));
      chk("wr_rlevel",  32'(rlevel),  32'h4);
      chk("wr_rempty",  32'(rempty),  32'h0);
      chk("wr_raempty", 32'(raempty), 32'h0);
    end

    // Writer frozen at binary 6; drain toward the almost-empty boundary
    cyc();
    chk("ae3_rlevel",  32'(rlevel),  32'h3);
    cyc();
    chk("ae2_rlevel",  32'(rlevel),  32'h2);
    chk("ae2_raempty", 32'(raempty), 32'h0);
    cyc();
    chk("ae1_rlevel",  32'(rlevel),  32'h1);
    chk("ae1_raempty", 32'(raempty), 32'h1);

    // Simultaneous read and writer advance at level 1
    rq2_wptr = gtab[7];
    cyc();
    chk("sim_rempty",  32'(rempty),  32'h0);
    chk("sim_rlevel",  32'(rlevel),  32'h1);
    chk("sim_raempty", 32'(raempty), 32'h1);
    chk("sim_raddr",   32'(raddr),   32'h6);
    cyc();
    rinc = 1'b0;
    chk("last_rempty", 32'(rempty), 32'h1);
    chk("last_rlevel", 32'(rlevel), 32'h0);
    chk("last_raddr",  32'(raddr),  32'h7);
    chk("last_under",  32'(runderflow), 32'h0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
